ubfly_out_collector: RTL and testbench

- Downstream stage of the pipelined unified butterfly; consumes its 16-bit outa/outb results.
- Tracks which butterfly cycles carry valid data using a delay line matched to the butterfly latency.
- Rounds, shifts and saturates each result to 8-bit signed, then buffers result pairs in a small FIFO with a valid/ready output.
- Exports an issue credit to the upstream sequencer, because the butterfly itself has no stall.

---
 rtl/ubfly_out_collector.sv | 166 ++++++++++++++++
 tb/tb_ubfly_out_collector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ubfly_out_collector.sv
// ubfly_out_collector
//   Output stage of the pipelined unified butterfly. A LAT-deep {valid, s}
//   delay line marks which butterfly cycles carry results. Each result lane is
//   rounded (half-up), arithmetically shifted by SHIFT and clamped to 8-bit
//   signed. Result pairs are queued in a DEPTH-entry FIFO with a valid/ready
//   output. An issue credit goes back upstream because the butterfly cannot
//   stall.
//
// Ports
//   clk, rst    clock; asynchronous active-high reset
//   in_valid    butterfly samples operands this cycle
//   in_s        mode bit issued with the operands (0=DIT, 1=DIF)
//   bf_outa/b   16-bit signed butterfly results, aligned with delay-line tail
//   can_issue   upstream may assert in_valid next cycle
//   m_valid     FIFO head valid
//   m_ready     consumer accepts the head
//   m_a/m_b     scaled 8-bit signed results of the head entry (0 when empty)
//   m_s         mode bit of the head entry (0 when empty)
//   sat_cnt     saturating count of clamped lanes
//   sat_clr     synchronous clear of sat_cnt (wins over an increment)
//   ovf         sticky: a result was dropped on a full FIFO
module ubfly_out_collector #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_s,
  input  logic [15:0] bf_outa,
  input  logic [15:0] bf_outb,
  output logic        can_issue,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_a,
  output logic [7:0]  m_b,
  output logic        m_s,
  output logic [7:0]  sat_cnt,
  input  logic        sat_clr,
  output logic        ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + LAT + 1);
  // 2^(SHIFT-1) for SHIFT>0, 0 for SHIFT=0
  localparam logic signed [16:0] RND = 17'((1 << SHIFT) >> 1);

  // Returns {saturated, r8}
  function automatic logic [8:0] scale(input logic [15:0] x);
    logic signed [16:0] t;
    t = $signed({x[15], x}) + RND;
    t = t >>> SHIFT;
    if (t > 17'sd127)       scale = {1'b1, 8'h7F};
    else if (t < -17'sd128) scale = {1'b1, 8'h80};
    else                    scale = {1'b0, t[7:0]};
  endfunction

  // Delay line
  logic [LAT-1:0] v_q, v_d;
  logic [LAT-1:0] s_q, s_d;

  // FIFO state; entry = {s, a8, b8}
  logic [16:0]   mem_q [DEPTH];
  logic [16:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [7:0] sat_cnt_q, sat_cnt_d;
  logic       ovf_q, ovf_d;

  logic        v_lat, s_lat;
  logic [8:0]  sc_a, sc_b;
  logic        full, pop, push;
  logic [1:0]  sat_inc;
  logic [8:0]  sat_sum;
  logic [CW-1:0] inflight;
  logic [16:0] head;

  always_comb begin
    v_d    = '0;
    s_d    = '0;
    v_d[0] = in_valid;
    s_d[0] = in_s;
    for (int unsigned i = 1; i < LAT; i++) begin
      v_d[i] = v_q[i-1];
      s_d[i] = s_q[i-1];
    end
  end

  assign v_lat = v_q[LAT-1];
  assign s_lat = s_q[LAT-1];

  always_comb begin
    sc_a = scale(bf_outa);
    sc_b = scale(bf_outb);
  end

  assign full = (count_q == (AW+1)'(DEPTH));
  assign pop  = m_valid && m_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push = v_lat && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {s_lat, sc_a[7:0], sc_b[7:0]};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_comb begin
    sat_inc   = {1'b0, sc_a[8]} + {1'b0, sc_b[8]};
    sat_sum   = {1'b0, sat_cnt_q} + {7'b0, sat_inc};
    sat_cnt_d = sat_cnt_q;
    if (v_lat) sat_cnt_d = sat_sum[8] ? 8'hFF : sat_sum[7:0];
    if (sat_clr) sat_cnt_d = '0;
    ovf_d = ovf_q | (v_lat && full && !pop);
  end

  // Credit uses registered state only; a pop frees a slot from the next cycle
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LAT; i++) inflight = inflight + CW'(v_q[i]);
    can_issue = (CW'(count_q) + inflight) < CW'(DEPTH);
  end

  always_comb begin
    head    = mem_q[rd_ptr_q];
    m_valid = (count_q != '0);
    m_a     = m_valid ? head[15:8] : '0;
    m_b     = m_valid ? head[7:0]  : '0;
    m_s     = m_valid ? head[16]   : 1'b0;
  end

  assign sat_cnt = sat_cnt_q;
  assign ovf     = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= '0;
      s_q       <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sat_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      v_q       <= v_d;
      s_q       <= s_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sat_cnt_q <= sat_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ubfly_out_collector.sv
module tb_ubfly_out_collector;

  logic        clk, rst, in_valid, in_s, m_ready, sat_clr;
  logic [15:0] bf_outa, bf_outb;
  logic        can_issue, m_valid, m_s, ovf;
  logic [7:0]  m_a, m_b, sat_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // Butterfly stand-in: results presented 4 cycles after issue
  logic [15:0] qa [4];
  logic [15:0] qb [4];

  ubfly_out_collector #(.LAT(4), .SHIFT(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_s(in_s),
    .bf_outa(bf_outa), .bf_outb(bf_outb), .can_issue(can_issue),
    .m_valid(m_valid), .m_ready(m_ready), .m_a(m_a), .m_b(m_b), .m_s(m_s),
    .sat_cnt(sat_cnt), .sat_clr(sat_clr), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic v, input logic s, input logic [15:0] a, input logic [15:0] b);
    in_valid = v;
    in_s     = s;
    bf_outa  = qa[3];
    bf_outb  = qb[3];
    qa[3] = qa[2]; qa[2] = qa[1]; qa[1] = qa[0]; qa[0] = a;
    qb[3] = qb[2]; qb[2] = qb[1]; qb[1] = qb[0]; qb[0] = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_s = 1'b0; m_ready = 1'b0; sat_clr = 1'b0;
    bf_outa = '0; bf_outb = '0;
    for (int i = 0; i < 4; i++) begin qa[i] = '0; qb[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_chk++; if (m_a !== 8'h00 || m_b !== 8'h00 || m_s !== 1'b0) begin n_fail++; $display("FAIL reset_data got %h %h %b want 00 00 0", m_a, m_b, m_s); end
    n_chk++; if (sat_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_sat_cnt got %h want 00", sat_cnt); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_chk++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL reset_can_issue got %b want 1", can_issue); end
  endtask

  task automatic test_single();
    cyc(1'b1, 1'b1, 16'd291, -16'sd300);
    idle(3);
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", m_valid); end
    idle(1);
    n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", m_valid); end
    n_chk++; if (m_a !== 8'h12 || m_b !== 8'hED || m_s !== 1'b1) begin n_fail++; $display("FAIL single_data got %h %h %b want 12 ed 1", m_a, m_b, m_s); end
    idle(2);
    n_chk++; if (m_valid !== 1'b1 || m_a !== 8'h12 || m_b !== 8'hED) begin n_fail++; $display("FAIL single_hold got %b %h %h want 1 12 ed", m_valid, m_a, m_b); end
    m_ready = 1'b1; idle(1); m_ready = 1'b0;
    n_chk++; if (m_valid !== 1'b0 || m_a !== 8'h00 || m_b !== 8'h00) begin n_fail++; $display("FAIL single_empty got %b %h %h want 0 00 00", m_valid, m_a, m_b); end
  endtask

  task automatic test_saturation();
    cyc(1'b1, 1'b0, 16'd16000, -16'sd16384);
    idle(4);
    n_chk++; if (m_a !== 8'h7F || m_b !== 8'h80) begin n_fail++; $display("FAIL sat_data got %h %h want 7f 80", m_a, m_b); end
    n_chk++; if (sat_cnt !== 8'd2) begin n_fail++; $display("FAIL sat_cnt got %0d want 2", sat_cnt); end
    m_ready = 1'b1; sat_clr = 1'b1; idle(1); sat_clr = 1'b0; m_ready = 1'b0;
    n_chk++; if (sat_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_clr got %0d want 0", sat_cnt); end
    // clear coinciding with a saturating push
    cyc(1'b1, 1'b0, 16'd16000, -16'sd16384);
    idle(3);
    sat_clr = 1'b1; idle(1); sat_clr = 1'b0;
    n_chk++; if (sat_cnt !== 8'd0 || m_valid !== 1'b1) begin n_fail++; $display("FAIL sat_clr_wins got %0d %b want 0 1", sat_cnt, m_valid); end
    m_ready = 1'b1; idle(1);
    for (int i = 0; i < 130; i++) cyc(1'b1, 1'b0, 16'd16000, -16'sd16384);
    idle(5); m_ready = 1'b0;
    n_chk++; if (sat_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt_max got %0d want 255", sat_cnt); end
    n_chk++; if (m_valid !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL sat_stream got %b %b want 0 0", m_valid, ovf); end
    sat_clr = 1'b1; idle(1); sat_clr = 1'b0;
    n_chk++; if (sat_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_clr2 got %0d want 0", sat_cnt); end
  endtask

  task automatic test_rounding();
    logic [7:0] ea [4];
    logic [7:0] eb [4];
    logic       es [4];
    ea = '{8'h01, 8'h00, 8'h7F, 8'h7F};
    eb = '{8'hFF, 8'h00, 8'h80, 8'h80};
    es = '{1'b0, 1'b1, 1'b0, 1'b1};
    m_ready = 1'b0;
    cyc(1'b1, 1'b0, 16'd8, -16'sd9);
    cyc(1'b1, 1'b1, 16'd7, -16'sd8);
    cyc(1'b1, 1'b0, 16'd2039, -16'sd2048);
    cyc(1'b1, 1'b1, 16'd2040, -16'sd2057);
    idle(4);
    n_chk++; if (sat_cnt !== 8'd2) begin n_fail++; $display("FAIL round_sat_cnt got %0d want 2", sat_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (m_valid !== 1'b1 || m_a !== ea[i] || m_b !== eb[i] || m_s !== es[i]) begin
        n_fail++; $display("FAIL round_%0d got %b %h %h %b want 1 %h %h %b", i, m_valid, m_a, m_b, m_s, ea[i], eb[i], es[i]);
      end
      m_ready = 1'b1; idle(1); m_ready = 1'b0;
    end
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL round_empty got %b want 0", m_valid); end
    sat_clr = 1'b1; idle(1); sat_clr = 1'b0;
  endtask

  task automatic fill8();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'(i % 2), 16'(16 * i), 16'(-16 * i));
      n_chk++;
      if (can_issue !== (i < 8)) begin n_fail++; $display("FAIL credit_after_%0d got %b want %b", i, can_issue, (i < 8)); end
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    fill8();
    n_chk++; if (m_valid !== 1'b1 || m_a !== 8'd1 || can_issue !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full got %b %h %b %b want 1 01 0 0", m_valid, m_a, can_issue, ovf);
    end
  endtask

  task automatic test_overflow();
    cyc(1'b1, 1'b1, 16'd144, -16'sd144);
    idle(5);
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf); end
    n_chk++; if (m_a !== 8'd1 || m_b !== 8'hFF || can_issue !== 1'b0) begin n_fail++; $display("FAIL ovf_head got %h %h %b want 01 ff 0", m_a, m_b, can_issue); end
    for (int i = 1; i <= 8; i++) begin
      n_chk++;
      if (m_valid !== 1'b1 || m_a !== 8'(i) || m_b !== 8'(-i) || m_s !== 1'(i % 2)) begin
        n_fail++; $display("FAIL drain_%0d got %b %h %h %b want 1 %h %h %b", i, m_valid, m_a, m_b, m_s, 8'(i), 8'(-i), 1'(i % 2));
      end
      m_ready = 1'b1; idle(1); m_ready = 1'b0;
    end
    n_chk++; if (m_valid !== 1'b0 || m_a !== 8'h00 || m_b !== 8'h00) begin n_fail++; $display("FAIL drain_empty got %b %h %h want 0 00 00", m_valid, m_a, m_b); end
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    fill8();
    cyc(1'b1, 1'b1, 16'd144, -16'sd144);
    idle(3);
    n_chk++; if (m_a !== 8'd1) begin n_fail++; $display("FAIL fpp_head_before got %h want 01", m_a); end
    m_ready = 1'b1; idle(1); m_ready = 1'b0;
    n_chk++; if (m_a !== 8'd2 || can_issue !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL fpp_after got %h %b %b want 02 0 0", m_a, can_issue, ovf);
    end
    for (int i = 2; i <= 9; i++) begin
      n_chk++;
      if (m_valid !== 1'b1 || m_a !== 8'(i) || m_b !== 8'(-i) || m_s !== 1'(i % 2)) begin
        n_fail++; $display("FAIL fpp_drain_%0d got %b %h %h %b want 1 %h %h %b", i, m_valid, m_a, m_b, m_s, 8'(i), 8'(-i), 1'(i % 2));
      end
      m_ready = 1'b1; idle(1); m_ready = 1'b0;
    end
    n_chk++; if (m_valid !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL fpp_end got %b %b want 0 0", m_valid, ovf); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 16'(16 * i), 16'(-16 * i));
    idle(1);
    n_chk++; if (m_valid !== 1'b1 || can_issue !== 1'b0) begin n_fail++; $display("FAIL rmf_pre got %b %b want 1 0", m_valid, can_issue); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (m_valid !== 1'b0 || can_issue !== 1'b1 || m_a !== 8'h00) begin
      n_fail++; $display("FAIL rmf_async got %b %b %h want 0 1 00", m_valid, can_issue, m_a);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      n_chk++; if (m_valid !== 1'b0 || can_issue !== 1'b1) begin n_fail++; $display("FAIL rmf_post_%0d got %b %b want 0 1", i, m_valid, can_issue); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
